smi_mem_lib_read_test_sequencer64: RTL and testbench

Upstream sequencer for the 64-bit SMI memory read burst test checker. Takes one run request (base address, burst length, burst count, counting-sequence seed), splits it into consecutive read bursts, and issues one test-parameter set per burst to the checker. It collects each burst's done status, counts failed bursts, and emits one summary result per run.

---
 rtl/smi_mem_lib_test_pkg.sv | 9 +
 rtl/smi_mem_lib_read_test_sequencer64_if.sv | 38 +++
 rtl/smi_mem_lib_read_test_sequencer64.sv | 68 ++++++
 tb/tb_smi_mem_lib_read_test_sequencer64.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/smi_mem_lib_test_pkg.sv
// smi_mem_lib_test_pkg: shared widths, word size and sequencer state encoding
package smi_mem_lib_test_pkg;
  localparam int ADDR_W = 64;
  localparam int LEN_W = 32;
  localparam int DATA_W = 64;
  localparam int OPTS_W = 8;
  localparam int WORD_BYTES = 8;
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, REPORT} state_t;
endpackage

// File: rtl/smi_mem_lib_read_test_sequencer64_if.sv
// smi_mem_lib_read_test_sequencer64_if: run, burst parameter, burst status and result handshakes
interface smi_mem_lib_read_test_sequencer64_if;
  import smi_mem_lib_test_pkg::*;
  logic runValid;
  logic [ADDR_W-1:0] runBaseAddr;
  logic [LEN_W-1:0] runBurstLen;
  logic [LEN_W-1:0] runBurstCount;
  logic [OPTS_W-1:0] runBurstOpts;
  logic [DATA_W-1:0] runDataInit;
  logic [DATA_W-1:0] runDataIncr;
  logic runStop;
  logic testParamsValid;
  logic [ADDR_W-1:0] testParamBurstAddr;
  logic [LEN_W-1:0] testParamBurstLen;
  logic [OPTS_W-1:0] testParamBurstOpts;
  logic [DATA_W-1:0] testParamDataInit;
  logic [DATA_W-1:0] testParamDataIncr;
  logic testParamsStop;
  logic testDoneValid;
  logic testDoneStatusOk;
  logic testDoneStop;
  logic resultValid;
  logic resultStatusOk;
  logic [LEN_W-1:0] resultFailCount;
  logic resultStop;
  modport master (
    input runValid, runBaseAddr, runBurstLen, runBurstCount, runBurstOpts, runDataInit, runDataIncr,
    input testParamsStop, testDoneValid, testDoneStatusOk, resultStop,
    output runStop, testParamsValid, testParamBurstAddr, testParamBurstLen, testParamBurstOpts,
    output testParamDataInit, testParamDataIncr, testDoneStop, resultValid, resultStatusOk, resultFailCount
  );
  modport slave (
    output runValid, runBaseAddr, runBurstLen, runBurstCount, runBurstOpts, runDataInit, runDataIncr,
    output testParamsStop, testDoneValid, testDoneStatusOk, resultStop,
    input runStop, testParamsValid, testParamBurstAddr, testParamBurstLen, testParamBurstOpts,
    input testParamDataInit, testParamDataIncr, testDoneStop, resultValid, resultStatusOk, resultFailCount
  );
endinterface

// File: rtl/smi_mem_lib_read_test_sequencer64.sv
// smi_mem_lib_read_test_sequencer64: splits a read test run into bursts and summarises their status
module smi_mem_lib_read_test_sequencer64
  import smi_mem_lib_test_pkg::*;
(
  input logic clk,
  input logic srst,
  smi_mem_lib_read_test_sequencer64_if.master bus
);
  state_t state, next;
  logic [ADDR_W-1:0] addr, addr_stride;
  logic [DATA_W-1:0] data_init, data_incr, data_stride;
  logic [LEN_W-1:0] len, count, remaining, fail_count;
  logic [OPTS_W-1:0] opts;
  logic run_ok;
  logic run_xfer, params_xfer, done_xfer, result_xfer;
  always_comb begin
    run_xfer = state == IDLE && bus.runValid;
    params_xfer = state == ISSUE && !bus.testParamsStop;
    done_xfer = state == WAIT && bus.testDoneValid;
    result_xfer = state == REPORT && !bus.resultStop;
    next = run_xfer ? SETUP :
           state == SETUP ? ((count == '0 || len == '0) ? REPORT : ISSUE) :
           params_xfer ? WAIT :
           done_xfer ? (remaining == LEN_W'(1) ? REPORT : ISSUE) :
           result_xfer ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk) begin
    if (srst || run_xfer) fail_count <= '0;
    else if (done_xfer) fail_count <= fail_count + LEN_W'(!bus.testDoneStatusOk);
  end
  // Datapath is left unreset; every field is loaded before the state machine reads it.
  always_ff @(posedge clk) begin
    if (run_xfer) begin
      addr <= bus.runBaseAddr;
      len <= bus.runBurstLen;
      count <= bus.runBurstCount;
      opts <= bus.runBurstOpts;
      data_init <= bus.runDataInit;
      data_incr <= bus.runDataIncr;
    end
    if (state == SETUP) begin
      addr_stride <= ADDR_W'(len) * ADDR_W'(WORD_BYTES);
      data_stride <= DATA_W'(len) * data_incr;
      remaining <= count;
      run_ok <= count == '0 || len != '0;
    end
    if (done_xfer) begin
      remaining <= remaining - LEN_W'(1);
      addr <= addr + addr_stride;
      data_init <= data_init + data_stride;
    end
  end
  assign bus.runStop = state != IDLE;
  assign bus.testParamsValid = state == ISSUE;
  assign bus.testParamBurstAddr = addr;
  assign bus.testParamBurstLen = len;
  assign bus.testParamBurstOpts = opts;
  assign bus.testParamDataInit = data_init;
  assign bus.testParamDataIncr = data_incr;
  assign bus.testDoneStop = state != WAIT;
  assign bus.resultValid = state == REPORT;
  assign bus.resultStatusOk = fail_count == '0 && run_ok;
  assign bus.resultFailCount = fail_count;
endmodule

// File: tb/tb_smi_mem_lib_read_test_sequencer64.sv
// tb_smi_mem_lib_read_test_sequencer64: randomized and directed runs checked against a burst-level model
module tb_smi_mem_lib_read_test_sequencer64;
  import smi_mem_lib_test_pkg::*;
  logic clk = 0;
  logic srst;
  always #5 clk = ~clk;
  smi_mem_lib_read_test_sequencer64_if bus();
  smi_mem_lib_read_test_sequencer64 dut (.clk(clk), .srst(srst), .bus(bus));
  int total = 0, bad = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  bit mon_en = 0, m_busy = 0, m_setup = 0;
  logic [63:0] m_base, m_init, m_incr;
  logic [31:0] m_len, m_count, m_issued = 0, m_done = 0, m_fail = 0;
  logic [7:0] m_opts;
  int cyc = 0, acc_cyc = 0, first_p_cyc = -1, first_r_cyc = -1, stall_cycles = 0, res_seen = 0;
  logic [63:0] q_addr[$], q_init[$];
  logic last_ok;
  logic [31:0] last_fail;
  bit ep, ew, er;
  // Expected behaviour is derived from burst counts: burst i sits at base + i*len*8.
  always @(negedge clk) begin
    cyc++;
    ep = m_busy && !m_setup && m_len != 0 && m_done < m_count && m_issued == m_done;
    ew = m_busy && m_issued > m_done;
    er = m_busy && !m_setup && (m_done == m_count || m_len == 0);
    if (mon_en) begin
      chk("runStop", 64'(bus.runStop), 64'(m_busy));
      chk("testParamsValid", 64'(bus.testParamsValid), 64'(ep));
      chk("testDoneStop", 64'(bus.testDoneStop), 64'(!ew));
      chk("resultValid", 64'(bus.resultValid), 64'(er));
      if (ep) begin
        chk("burst_addr", bus.testParamBurstAddr, m_base + 64'(m_issued) * 64'(m_len) * 64'(WORD_BYTES));
        chk("burst_data_init", bus.testParamDataInit, m_init + 64'(m_issued) * 64'(m_len) * m_incr);
        chk("burst_len", 64'(bus.testParamBurstLen), 64'(m_len));
        chk("burst_opts", 64'(bus.testParamBurstOpts), 64'(m_opts));
        chk("burst_incr", bus.testParamDataIncr, m_incr);
      end
      if (er) begin
        chk("result_ok", 64'(bus.resultStatusOk), 64'(m_count == 0 || (m_len != 0 && m_fail == 0)));
        chk("result_fail_count", 64'(bus.resultFailCount), 64'(m_fail));
      end
    end
    if (bus.testParamsValid === 1'b1) begin
      if (first_p_cyc < 0) first_p_cyc = cyc;
      if (bus.testParamsStop) stall_cycles++;
      else begin
        q_addr.push_back(bus.testParamBurstAddr);
        q_init.push_back(bus.testParamDataInit);
      end
    end
    if (bus.resultValid === 1'b1) begin
      if (first_r_cyc < 0) first_r_cyc = cyc;
      if (!bus.resultStop) begin
        last_ok = bus.resultStatusOk;
        last_fail = bus.resultFailCount;
        res_seen++;
      end
    end
    if (srst) begin
      m_busy = 0; m_setup = 0; m_issued = 0; m_done = 0; m_fail = 0;
    end else if (!m_busy && bus.runValid) begin
      m_base = bus.runBaseAddr; m_len = bus.runBurstLen; m_count = bus.runBurstCount;
      m_opts = bus.runBurstOpts; m_init = bus.runDataInit; m_incr = bus.runDataIncr;
      m_busy = 1; m_setup = 1; m_issued = 0; m_done = 0; m_fail = 0; acc_cyc = cyc;
    end else if (m_setup) m_setup = 0;
    else begin
      if (ep && !bus.testParamsStop) m_issued++;
      if (ew && bus.testDoneValid) begin
        m_done++;
        m_fail += {31'b0, ~bus.testDoneStatusOk};
      end
      if (er && !bus.resultStop) m_busy = 0;
    end
  end
  int fail_mode = 0, max_lat = 0, stall_cnt = 0, burst_no = 0;
  bit rand_stop = 0;
  initial begin
    int lat;
    bit pend, p_x, d_x, v_seen, rs;
    pend = 0; lat = 0;
    bus.testDoneValid = 0; bus.testDoneStatusOk = 1; bus.testParamsStop = 0; bus.resultStop = 0;
    forever begin
      @(negedge clk);
      p_x = bus.testParamsValid === 1'b1 && !bus.testParamsStop;
      d_x = bus.testDoneValid && bus.testDoneStop === 1'b0;
      v_seen = bus.testParamsValid === 1'b1;
      rs = srst;
      @(posedge clk);
      #1;
      if (rs) begin
        bus.testDoneValid = 0;
        pend = 0;
      end else begin
        if (d_x) bus.testDoneValid = 0;
        if (p_x) begin
          pend = 1;
          lat = $urandom_range(0, max_lat);
          burst_no++;
        end
        if (pend && !bus.testDoneValid) begin
          if (lat == 0) begin
            bus.testDoneValid = 1;
            bus.testDoneStatusOk = fail_mode == 0 ? 1'b1 : fail_mode == 1 ? (burst_no != 2) :
                                   fail_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
            pend = 0;
          end else lat--;
        end
      end
      if (stall_cnt > 0 && v_seen) stall_cnt--;
      bus.testParamsStop = stall_cnt > 0 || (rand_stop && $urandom_range(0, 2) == 0);
      bus.resultStop = rand_stop && $urandom_range(0, 2) == 0;
    end
  end
  task automatic start_run(logic [63:0] base, logic [31:0] len, logic [31:0] count, logic [7:0] opts,
                           logic [63:0] init, logic [63:0] incr);
    int n = 0;
    while (bus.runStop !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    q_addr.delete(); q_init.delete();
    first_p_cyc = -1; first_r_cyc = -1; stall_cycles = 0; burst_no = 0;
    bus.runBaseAddr = base; bus.runBurstLen = len; bus.runBurstCount = count;
    bus.runBurstOpts = opts; bus.runDataInit = init; bus.runDataIncr = incr;
    bus.runValid = 1;
    @(posedge clk);
    #1;
    bus.runValid = 0;
  endtask
  task automatic do_run(logic [63:0] base, logic [31:0] len, logic [31:0] count, logic [7:0] opts,
                        logic [63:0] init, logic [63:0] incr);
    int r0 = res_seen;
    int n = 0;
    start_run(base, len, count, opts, init, incr);
    while (res_seen == r0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("run_completed", 64'(res_seen - r0), 64'd1);
  endtask
  initial begin
    int n;
    srst = 1;
    bus.runValid = 0; bus.runBaseAddr = 0; bus.runBurstLen = 0; bus.runBurstCount = 0;
    bus.runBurstOpts = 0; bus.runDataInit = 0; bus.runDataIncr = 0;
    @(posedge clk);
    #1 mon_en = 1;
    repeat (2) @(posedge clk);
    #1 srst = 0;
    @(negedge clk);
    chk("reset_runStop", 64'(bus.runStop), 64'd0);
    chk("reset_testParamsValid", 64'(bus.testParamsValid), 64'd0);
    chk("reset_testDoneStop", 64'(bus.testDoneStop), 64'd1);
    chk("reset_resultValid", 64'(bus.resultValid), 64'd0);
    chk("reset_failCount", 64'(bus.resultFailCount), 64'd0);
    do_run(64'h1000, 4, 3, 8'h5A, 0, 1);
    chk("t1_bursts", 64'(q_addr.size()), 64'd3);
    if (q_addr.size() == 3) begin
      chk("t1_addr0", q_addr[0], 64'h1000); chk("t1_addr1", q_addr[1], 64'h1020); chk("t1_addr2", q_addr[2], 64'h1040);
      chk("t1_init0", q_init[0], 64'd0); chk("t1_init1", q_init[1], 64'd4); chk("t1_init2", q_init[2], 64'd8);
    end
    chk("t1_first_params_latency", 64'(first_p_cyc - acc_cyc), 64'd2);
    chk("t1_ok", 64'(last_ok), 64'd1);
    chk("t1_fail", 64'(last_fail), 64'd0);
    fail_mode = 1;
    do_run(64'h1000, 4, 3, 8'h5A, 0, 1);
    chk("t2_ok", 64'(last_ok), 64'd0);
    chk("t2_fail", 64'(last_fail), 64'd1);
    fail_mode = 0;
    do_run(64'h2000, 4, 0, 8'h00, 0, 1);
    chk("t3_bursts", 64'(q_addr.size()), 64'd0);
    chk("t3_result_latency", 64'(first_r_cyc - acc_cyc), 64'd2);
    chk("t3_ok", 64'(last_ok), 64'd1);
    chk("t3_fail", 64'(last_fail), 64'd0);
    do_run(64'h3000, 0, 5, 8'h00, 0, 1);
    chk("t4_bursts", 64'(q_addr.size()), 64'd0);
    chk("t4_ok", 64'(last_ok), 64'd0);
    chk("t4_fail", 64'(last_fail), 64'd0);
    stall_cnt = 5;
    do_run(64'hFFFF_FFFF_FFFF_FFF0, 2, 2, 8'h11, 64'h10, 64'h3);
    chk("t5_bursts", 64'(q_addr.size()), 64'd2);
    if (q_addr.size() == 2) begin
      chk("t5_addr0", q_addr[0], 64'hFFFF_FFFF_FFFF_FFF0);
      chk("t5_addr1_wrap", q_addr[1], 64'h0);
      chk("t5_init1", q_init[1], 64'h16);
    end
    chk("t5_stall_cycles", 64'(stall_cycles), 64'd5);
    fail_mode = 2; max_lat = 2;
    start_run(64'h4000, 4, 3, 8'h00, 0, 1);
    n = 0;
    while (!(bus.testDoneStop === 1'b0 && m_done >= 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_wait", 64'(bus.testDoneStop), 64'd0);
    @(posedge clk);
    #1 srst = 1;
    @(posedge clk);
    #1 srst = 0;
    @(negedge clk);
    chk("t6_runStop", 64'(bus.runStop), 64'd0);
    chk("t6_testDoneStop", 64'(bus.testDoneStop), 64'd1);
    chk("t6_failCount", 64'(bus.resultFailCount), 64'd0);
    fail_mode = 0; max_lat = 0;
    do_run(64'h5000, 2, 2, 8'h00, 0, 1);
    chk("t6_new_ok", 64'(last_ok), 64'd1);
    chk("t6_new_fail", 64'(last_fail), 64'd0);
    fail_mode = 3; max_lat = 3; rand_stop = 1;
    for (int i = 0; i < 25; i++)
      do_run({$urandom, $urandom}, $urandom_range(0, 5), $urandom_range(0, 4), 8'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
